// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and helpers for the branch predictor.
// Holds the 2-bit BHT counter encodings, the counter reset value and the
// saturating counter update used by the counter array.
package branch_predict_unit_pkg;

    localparam logic [1:0] BHT_SNT       = 2'b00;   // strongly not-taken
    localparam logic [1:0] BHT_WNT       = 2'b01;   // weakly not-taken
    localparam logic [1:0] BHT_WT        = 2'b10;   // weakly taken
    localparam logic [1:0] BHT_ST        = 2'b11;   // strongly taken
    localparam logic [1:0] BHT_RESET_VAL = BHT_WNT;

    // Saturating step toward the observed outcome.
    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == BHT_ST) ? BHT_ST : cnt + 2'd1;
        end else begin
            res = (cnt == BHT_SNT) ? BHT_SNT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht_counter_array.sv
// 2^IDX_W x 2-bit saturating counter table.
// Ports:
//   clk, rst      clock, synchronous active-high reset (all entries -> WNT)
//   rd_idx_i      lookup index
//   rd_cnt_c_o    counter at rd_idx_i, combinational (pre-update on same-index write)
//   wr_en_i       train enable
//   wr_idx_i      train index
//   wr_taken_i    observed outcome used for the saturating update
module bht_counter_array
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_c_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int unsigned NUM_ENTRIES = 2 ** IDX_W;

    logic [1:0] cnt_q [NUM_ENTRIES];

    // Async read returns the stored value, so a same-cycle write is not forwarded.
    assign rd_cnt_c_o = cnt_q[rd_idx_i];

    // Counter storage with single training port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cnt_q[i] <= BHT_RESET_VAL;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= bht_next(cnt_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor with ID-stage resolution.
// IF looks up a 2-bit counter for if_pc; the guess rides with the instruction
// into ID where it is compared against the evaluated outcome. A mismatch raises
// a one-cycle flush with the correct next PC and bumps a saturating statistic.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_pc, if_valid                   IF-stage instruction
//   if_pred_taken                     combinational guess for if_pc
//   stall_in                          ID operand stall; blocks resolve and training
//   id_branch, id_pc, id_actual_taken, id_target   ID-stage branch info
//   id_pred_taken                     registered guess for the IF/ID instruction
//   flush, redirect_pc                mispredict squash pulse and correct next PC
//   mispredict_cnt                    saturating mispredict count
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_valid,
    output logic             if_pred_taken,
    input  logic             stall_in,
    input  logic             id_branch,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_actual_taken,
    input  logic [XLEN-1:0]  id_target,
    output logic             id_pred_taken,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [BHT_IDX_W-1:0] if_idx_c;
    logic [BHT_IDX_W-1:0] id_idx_c;
    logic [1:0]           if_cnt_c;
    logic                 resolve_c;
    logic                 mispredict_c;

    logic             id_pred_taken_q, id_pred_taken_d;
    logic             id_vld_q,        id_vld_d;
    logic             flush_q,         flush_d;
    logic [XLEN-1:0]  redirect_pc_q,   redirect_pc_d;
    logic [CNT_W-1:0] cnt_q,           cnt_d;

    // Only the word-index bits of if_pc select a counter.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

    assign if_idx_c = if_pc[BHT_IDX_W+1:2];
    assign id_idx_c = id_pc[BHT_IDX_W+1:2];

    bht_counter_array #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_idx_c),
        .rd_cnt_c_o (if_cnt_c),
        .wr_en_i    (resolve_c),
        .wr_idx_i   (id_idx_c),
        .wr_taken_i (id_actual_taken)
    );

    assign if_pred_taken = if_cnt_c[1];

    // A flushed slot is a bubble, so it can never resolve (no back-to-back flush).
    assign resolve_c    = id_vld_q & id_branch & ~stall_in & ~flush_q;
    assign mispredict_c = resolve_c & (id_actual_taken != id_pred_taken_q);

    // Next-state: IF->ID pipe, flush pulse, redirect target, statistics.
    always_comb begin
        id_pred_taken_d = id_pred_taken_q;
        id_vld_d        = id_vld_q;
        redirect_pc_d   = redirect_pc_q;
        cnt_d           = cnt_q;
        flush_d         = mispredict_c;

        if (flush_q) begin
            id_pred_taken_d = 1'b0;
            id_vld_d        = 1'b0;
        end else if (!stall_in) begin
            id_pred_taken_d = if_valid & if_pred_taken;
            id_vld_d        = if_valid;
        end

        if (mispredict_c) begin
            redirect_pc_d = id_actual_taken ? id_target : id_pc + XLEN'(4);
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops any resolution pending in this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pred_taken_q <= 1'b0;
            id_vld_q        <= 1'b0;
            flush_q         <= 1'b0;
            redirect_pc_q   <= '0;
            cnt_q           <= '0;
        end else begin
            id_pred_taken_q <= id_pred_taken_d;
            id_vld_q        <= id_vld_d;
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            cnt_q           <= cnt_d;
        end
    end

    assign id_pred_taken  = id_pred_taken_q;
    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: expected flush events are queued
// as branches are issued and a monitor pops them whenever flush is seen.
module tb_branch_predict_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  if_pc;
    logic             if_valid;
    logic             if_pred_taken;
    logic             stall_in;
    logic             id_branch;
    logic [XLEN-1:0]  id_pc;
    logic             id_actual_taken;
    logic [XLEN-1:0]  id_target;
    logic             id_pred_taken;
    logic             flush;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    branch_predict_unit #(
        .BHT_IDX_W (IDX_W),
        .XLEN      (XLEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .if_pred_taken   (if_pred_taken),
        .stall_in        (stall_in),
        .id_branch       (id_branch),
        .id_pc           (id_pc),
        .id_actual_taken (id_actual_taken),
        .id_target       (id_target),
        .id_pred_taken   (id_pred_taken),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .mispredict_cnt  (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]  redirect;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] model [16];
    logic [CNT_W-1:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [XLEN-1:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic logic [1:0] step(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    // Monitor: every flush must match the oldest queued expectation.
    always @(negedge clk) begin
        if (flush === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_flush", 32'(flush), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("redirect_pc", redirect_pc, e.redirect);
                check("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; stall_in = 1'b0;
        id_branch = 1'b0; id_pc = '0; id_actual_taken = 1'b0; id_target = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 2'b01;
        model_cnt = '0;
        sb.delete();
    endtask

    // Fetch pc (cycle A), optionally stall, resolve (cycle B), observe (cycle C).
    // look_pc is looked up in B and C to see pre- and post-training values.
    task automatic run_branch(input logic [XLEN-1:0] pc, input logic is_br,
                              input logic taken, input logic [XLEN-1:0] target,
                              input logic [XLEN-1:0] look_pc, input int stalls);
        logic pred;
        if_valid = 1'b1; if_pc = pc; id_branch = 1'b0; stall_in = 1'b0;
        @(negedge clk);
        pred = model[idx(pc)][1];
        check("lookup_fetch", 32'(if_pred_taken), 32'(pred));
        @(posedge clk); #1;
        check("id_pred_taken", 32'(id_pred_taken), 32'(pred));

        if_pc = look_pc; id_branch = is_br; id_pc = pc; id_target = target;
        for (int s = 0; s < stalls; s++) begin
            stall_in = 1'b1;
            id_actual_taken = (s % 2 == 0) ? ~taken : taken;
            @(negedge clk);
            check("stall_no_train", 32'(if_pred_taken), 32'(model[idx(look_pc)][1]));
            @(posedge clk); #1;
            check("stall_hold", 32'(id_pred_taken), 32'(pred));
        end

        stall_in = 1'b0; if_valid = 1'b0; id_actual_taken = taken;
        @(negedge clk);
        check("lookup_resolve", 32'(if_pred_taken), 32'(model[idx(look_pc)][1]));
        if (is_br) begin
            if (taken != pred) begin
                if (model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + CNT_W'(1);
                sb.push_back('{redirect: taken ? target : pc + 32'd4, cnt: model_cnt});
            end
            model[idx(pc)] = step(model[idx(pc)], taken);
        end
        @(posedge clk); #1;

        id_branch = 1'b0;
        @(negedge clk);
        check("lookup_after", 32'(if_pred_taken), 32'(model[idx(look_pc)][1]));
        #1;
        check("flush_missing", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        check("bubble_pred", 32'(id_pred_taken), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state: every index weakly not-taken, outputs clear.
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            check("reset_lookup", 32'(if_pred_taken), 32'd0);
        end
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_cnt", 32'(mispredict_cnt), 32'd0);
        check("reset_id_pred", 32'(id_pred_taken), 32'd0);
        @(posedge clk); #1;

        // Training at 0x40: mispredict then correct.
        run_branch(32'h40, 1'b1, 1'b1, 32'h100, 32'h40, 0);
        run_branch(32'h40, 1'b1, 1'b1, 32'h100, 32'h40, 0);
        check("train_pred_0x40", 32'(if_pred_taken), 32'd1);
        check("train_cnt", 32'(mispredict_cnt), 32'd1);

        // Stall hold with flipping outcome.
        run_branch(32'h88, 1'b1, 1'b1, 32'h200, 32'h88, 3);
        check("stall_cnt", 32'(mispredict_cnt), 32'd2);

        // Top-of-memory branch: train to ST, then not-taken wraps to 0.
        run_branch(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h300, 32'hFFFF_FFFC, 0);
        run_branch(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h300, 32'hFFFF_FFFC, 0);
        run_branch(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h300, 32'hFFFF_FFFC, 0);
        run_branch(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h300, 32'hFFFF_FFFC, 0);
        check("sat_cnt", 32'(mispredict_cnt), 32'd3);

        // Same-index collision on index 5.
        run_branch(32'h14, 1'b1, 1'b1, 32'h500, 32'h14, 0);

        // Non-branch in ID: no training, no flush.
        run_branch(32'h14, 1'b0, 1'b0, 32'h600, 32'h14, 0);
        check("nonbr_cnt", 32'(mispredict_cnt), 32'd3);

        // Reset in the resolve cycle of a mispredicting branch.
        do_reset();
        if_valid = 1'b1; if_pc = 32'h40;
        @(posedge clk); #1;
        if_valid = 1'b0; id_branch = 1'b1; id_pc = 32'h40;
        id_actual_taken = 1'b1; id_target = 32'h700; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; id_branch = 1'b0;
        check("rst_pending_flush", 32'(flush), 32'd0);
        check("rst_pending_cnt", 32'(mispredict_cnt), 32'd0);
        check("rst_pending_id_pred", 32'(id_pred_taken), 32'd0);
        check("rst_pending_lookup", 32'(if_pred_taken), 32'd0);
        @(posedge clk); #1;
        check("rst_pending_flush2", 32'(flush), 32'd0);
        check("final_queue", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
